// File: rtl/game_sequencer_pkg.sv
// Purpose: shared Frogger game-flow types, default constants and car-speed helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: state_t (one-hot round state), default parameter values,
// speed saturation limit and sat_speed().
package frogger_pkg;

    // One-hot round states; GAME_OVER stays in the type even when the lives
    // feature is compiled out so every build shares one encoding.
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        PLAY      = 5'b00010,
        DYING     = 5'b00100,
        LEVEL_UP  = 5'b01000,
        GAME_OVER = 5'b10000
    } state_t;

    localparam int DEF_MAX_LEVEL    = 9;
    localparam int DEF_START_LIVES  = 3;
    localparam int DEF_PAUSE_FRAMES = 60;
    localparam int DEF_SPEED_BASE   = 1;
    localparam int SPEED_SAT        = 15;

    // Car speed for a level: base + level, clamped to the 4-bit ceiling.
    function automatic logic [3:0] sat_speed(input int base, input logic [3:0] lvl);
        int sum;
        sum = base + int'(lvl);
        if (sum > SPEED_SAT) begin
            return 4'(SPEED_SAT);
        end
        return 4'(sum);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Purpose: bundles the game sequencer's event inputs and game-state outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/pulse, no handshake.
//
// master: top-level glue driving frame/collision/switch events.
// slave : the sequencer, producing round_reset, freeze, level, lives,
//         car_speed and game_over.
interface game_sequencer_if;
    logic       frame_tick;
    logic       death_collision;
    logic       win_collision;
    logic       any_move;
    logic       restart;
    logic       round_reset;
    logic       freeze;
    logic [3:0] level;
    logic [1:0] lives;
    logic [3:0] car_speed;
    logic       game_over;

    modport master (
        output frame_tick, death_collision, win_collision, any_move, restart,
        input  round_reset, freeze, level, lives, car_speed, game_over
    );

    modport slave (
        input  frame_tick, death_collision, win_collision, any_move, restart,
        output round_reset, freeze, level, lives, car_speed, game_over
    );
endinterface

// File: rtl/game_sequencer_rise_detect.sv
// Purpose: 1-bit rising-edge detector (registered previous value).
// Latency: combinational edge output, valid in the same cycle the input rises.
// Backpressure: none.
//
// Ports: clk, reset_n (async active-low), d (level input), rise (d high now, low last cycle).
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;
endmodule

// File: rtl/game_sequencer.sv
// Purpose: Frogger round sequencer (attract, play, death/level-up pauses, game over).
// Latency: an input edge sampled in cycle N is reflected on all outputs at N+1.
// Backpressure: none; inputs are sampled every cycle and never stalled.
//
// Ports: clk, reset_n (async active-low), bus (game_sequencer_if.slave):
//   in  frame_tick, death_collision, win_collision, any_move, restart
//   out round_reset, freeze, level[3:0], lives[1:0], car_speed[3:0], game_over
// Build option: GAME_SEQ_LIVES_EN enables lives counting and the GAME_OVER state;
// without it lives is fixed at START_LIVES and game_over is 0.
module game_sequencer
    import frogger_pkg::*;
#(
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int START_LIVES  = DEF_START_LIVES,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES,
    parameter int SPEED_BASE   = DEF_SPEED_BASE
) (
    input  logic            clk,
    input  logic            reset_n,
    game_sequencer_if.slave bus
);
    localparam int               CNT_RAW    = $clog2(PAUSE_FRAMES + 1);
    localparam int               CNT_W      = (CNT_RAW < 6) ? 6 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [3:0]       LEVEL_TOP  = 4'(MAX_LEVEL);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0]       SPEED_INIT = sat_speed(SPEED_BASE, 4'd0);

    state_t           state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       speed_q;
    logic             rr_q, rr_d;
    logic             restart_q;
    logic             enter_play;
    logic             pause_done;
    logic             death_edge, win_edge, move_edge;
`ifdef GAME_SEQ_LIVES_EN
    logic [1:0]       lives_q, lives_d;
`endif

    rise_detect u_death_edge (.clk(clk), .reset_n(reset_n), .d(bus.death_collision), .rise(death_edge));
    rise_detect u_win_edge   (.clk(clk), .reset_n(reset_n), .d(bus.win_collision),   .rise(win_edge));
    rise_detect u_move_edge  (.clk(clk), .reset_n(reset_n), .d(bus.any_move),        .rise(move_edge));

    // The tick that completes the pause is the one seen when the count
    // already holds PAUSE_FRAMES-1.
    assign pause_done = bus.frame_tick && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        enter_play = 1'b0;
`ifdef GAME_SEQ_LIVES_EN
        lives_d    = lives_q;
`endif
        if (bus.restart) begin
            state_d = IDLE;
            level_d = 4'd0;
            cnt_d   = '0;
`ifdef GAME_SEQ_LIVES_EN
            lives_d = LIVES_INIT;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (move_edge) begin
                        state_d    = PLAY;
                        enter_play = 1'b1;
                    end
                end
                PLAY: begin
                    // Win wins a same-cycle tie with death; lives untouched.
                    if (win_edge) begin
                        state_d = LEVEL_UP;
                        level_d = (level_q == LEVEL_TOP) ? 4'd0 : level_q + 4'd1;
                        cnt_d   = '0;
                    end else if (death_edge) begin
                        state_d = DYING;
                        cnt_d   = '0;
`ifdef GAME_SEQ_LIVES_EN
                        lives_d = lives_q - 2'd1;
`endif
                    end
                end
                DYING, LEVEL_UP: begin
                    if (pause_done) begin
`ifdef GAME_SEQ_LIVES_EN
                        // lives already reads 0 if this death used the last life.
                        if (state_q == DYING && lives_q == 2'd0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d    = PLAY;
                            enter_play = 1'b1;
                        end
`else
                        state_d    = PLAY;
                        enter_play = 1'b1;
`endif
                    end else if (bus.frame_tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef GAME_SEQ_LIVES_EN
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // A held restart pulses once; the mask keeps round_reset from ever
        // being high on two consecutive cycles.
        rr_d = (enter_play | (bus.restart & ~restart_q)) & ~rr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            level_q   <= 4'd0;
            cnt_q     <= '0;
            rr_q      <= 1'b0;
            restart_q <= 1'b0;
            speed_q   <= SPEED_INIT;
`ifdef GAME_SEQ_LIVES_EN
            lives_q   <= LIVES_INIT;
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            restart_q <= bus.restart;
            // Computed from the next level so speed and level move together.
            speed_q   <= sat_speed(SPEED_BASE, level_d);
`ifdef GAME_SEQ_LIVES_EN
            lives_q   <= lives_d;
`endif
        end
    end

    assign bus.round_reset = rr_q;
    assign bus.freeze      = (state_q != PLAY);
    assign bus.level       = level_q;
    assign bus.car_speed   = speed_q;
`ifdef GAME_SEQ_LIVES_EN
    assign bus.lives       = lives_q;
    assign bus.game_over   = (state_q == GAME_OVER);
`else
    assign bus.lives       = LIVES_INIT;
    assign bus.game_over   = 1'b0;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// Purpose: randomized scoreboard bench for game_sequencer against a round-level model.
// Latency: expectations are pushed when inputs are applied and popped one clock later.
// Backpressure: none; the monitor compares every cycle an expectation is queued.
module tb_game_sequencer;
    localparam int MAX_LEVEL    = 9;
    localparam int START_LIVES  = 3;
    localparam int PAUSE_FRAMES = 60;
    localparam int SPEED_BASE   = 1;
`ifdef GAME_SEQ_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    game_sequencer_if bus();

    game_sequencer #(
        .MAX_LEVEL   (MAX_LEVEL),
        .START_LIVES (START_LIVES),
        .PAUSE_FRAMES(PAUSE_FRAMES),
        .SPEED_BASE  (SPEED_BASE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rr;
        bit frz;
        int lvl;
        int lv;
        int spd;
        bit go;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one round at a time ----------------
    typedef enum int {M_IDLE, M_PLAY, M_DYING, M_LVLUP, M_OVER} mode_t;
    mode_t m_mode;
    int    m_level, m_lives, m_ticks;
    bit    p_death, p_win, p_move, p_rst, m_rr;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_level = 0;
        m_lives = START_LIVES;
        m_ticks = 0;
        p_death = 0; p_win = 0; p_move = 0; p_rst = 0;
        m_rr    = 0;
    endtask

    task automatic model_step(input bit tk, input bit d, input bit w, input bit mv, input bit rs);
        bit de, we, me, re, pulse;
        de = d && !p_death;
        we = w && !p_win;
        me = mv && !p_move;
        re = rs && !p_rst;
        p_death = d; p_win = w; p_move = mv; p_rst = rs;
        pulse = 0;
        if (rs) begin
            m_mode  = M_IDLE;
            m_level = 0;
            m_lives = START_LIVES;
            m_ticks = 0;
            pulse   = re;
        end else begin
            case (m_mode)
                M_IDLE: if (me) begin m_mode = M_PLAY; pulse = 1; end
                M_PLAY: begin
                    if (we) begin
                        m_mode  = M_LVLUP;
                        m_level = (m_level == MAX_LEVEL) ? 0 : m_level + 1;
                        m_ticks = 0;
                    end else if (de) begin
                        m_mode  = M_DYING;
                        m_ticks = 0;
                        if (LIVES_EN) m_lives = m_lives - 1;
                    end
                end
                M_DYING, M_LVLUP: begin
                    if (tk) begin
                        m_ticks++;
                        if (m_ticks == PAUSE_FRAMES) begin
                            if (m_mode == M_DYING && LIVES_EN && m_lives == 0) begin
                                m_mode = M_OVER;
                            end else begin
                                m_mode = M_PLAY;
                                pulse  = 1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        m_rr = pulse && !m_rr;
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.rr  = m_rr;
        e.frz = (m_mode != M_PLAY);
        e.lvl = m_level;
        e.lv  = LIVES_EN ? m_lives : START_LIVES;
        e.spd = (SPEED_BASE + m_level > 15) ? 15 : SPEED_BASE + m_level;
        e.go  = (m_mode == M_OVER);
        return e;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("round_reset", int'(bus.round_reset), int'(e.rr));
            chk("freeze",      int'(bus.freeze),      int'(e.frz));
            chk("level",       int'(bus.level),       e.lvl);
            chk("lives",       int'(bus.lives),       e.lv);
            chk("car_speed",   int'(bus.car_speed),   e.spd);
            chk("game_over",   int'(bus.game_over),   int'(e.go));
        end
    end

    // ---------------- stimulus ----------------
    function automatic bit coin(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Apply one cycle of inputs; called at negedge+1, returns at the next negedge+1.
    task automatic drive(input bit tk, input bit d, input bit w, input bit mv, input bit rs);
        bus.frame_tick      = tk;
        bus.death_collision = d;
        bus.win_collision   = w;
        bus.any_move        = mv;
        bus.restart         = rs;
        model_step(tk, d, w, mv, rs);
        exp_q.push_back(model_expect());
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pause(input string name, input int budget);
        int n;
        bit expired;
        n = 0;
        while ((m_mode == M_DYING || m_mode == M_LVLUP) && n < budget) begin
            drive(coin(50), 0, 0, 0, 0);
            n++;
        end
        expired = (m_mode == M_DYING || m_mode == M_LVLUP);
        chk({name, "_budget"}, int'(expired), 0);
        chk({name, "_freeze"}, int'(bus.freeze), (m_mode == M_PLAY) ? 0 : 1);
    endtask

    initial begin
        reset_n             = 1'b0;
        bus.frame_tick      = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
        bus.any_move        = 1'b0;
        bus.restart         = 1'b0;
        model_reset();
        exp_q.push_back(model_expect());
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) drive(coin(50), 0, 0, 0, 0);

        // First move starts play with a single round_reset.
        drive(0, 0, 0, 1, 0);
        chk("start_rr",     int'(bus.round_reset), 1);
        chk("start_freeze", int'(bus.freeze),      0);
        chk("start_level",  int'(bus.level),       0);
        chk("start_lives",  int'(bus.lives),       START_LIVES);
        chk("start_speed",  int'(bus.car_speed),   1);
        drive(0, 0, 0, 0, 0);
        chk("start_rr_once", int'(bus.round_reset), 0);
        repeat (5) drive(coin(50), 0, 0, 0, 0);

        // Win held high: one level step only.
        repeat (20) drive(coin(50), 0, 1, 0, 0);
        chk("win_level", int'(bus.level),     1);
        chk("win_speed", int'(bus.car_speed), 2);
        drive(coin(50), 0, 0, 0, 0);
        wait_pause("win_pause", 2000);

        // Three deaths with full pauses.
        for (int i = 0; i < 3; i++) begin
            drive(coin(50), 1, 0, 0, 0);
            chk("death_lives", int'(bus.lives), LIVES_EN ? START_LIVES - 1 - i : START_LIVES);
            drive(coin(50), 1, 0, 0, 0);
            drive(coin(50), 0, 0, 0, 0);
            wait_pause("death_pause", 2000);
            repeat (3) drive(coin(50), 0, 0, 0, 0);
        end
        chk("game_over", int'(bus.game_over), int'(LIVES_EN));
        repeat (4) begin
            drive(coin(50), 0, 0, 1, 0);
            drive(coin(50), 0, 0, 0, 0);
        end
        chk("go_sticky", int'(bus.game_over), int'(LIVES_EN));
        drive(0, 0, 0, 0, 1);
        chk("restart_rr",    int'(bus.round_reset), 1);
        chk("restart_level", int'(bus.level),       0);
        chk("restart_lives", int'(bus.lives),       START_LIVES);
        chk("restart_go",    int'(bus.game_over),   0);
        chk("restart_frz",   int'(bus.freeze),      1);
        drive(0, 0, 0, 0, 0);
        chk("restart_rr_once", int'(bus.round_reset), 0);

        // Climb to the top level, then tie win and death.
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < MAX_LEVEL; i++) begin
            drive(coin(50), 0, 1, 0, 0);
            drive(coin(50), 0, 0, 0, 0);
            wait_pause("climb_pause", 2000);
        end
        chk("top_level", int'(bus.level),     MAX_LEVEL);
        chk("top_speed", int'(bus.car_speed), SPEED_BASE + MAX_LEVEL);
        drive(0, 1, 1, 0, 0);
        chk("tie_level",  int'(bus.level),     0);
        chk("tie_lives",  int'(bus.lives),     START_LIVES);
        chk("tie_freeze", int'(bus.freeze),    1);
        chk("tie_speed",  int'(bus.car_speed), SPEED_BASE);
        drive(0, 0, 0, 0, 0);
        wait_pause("tie_pause", 2000);

        // Restart after 30 counted ticks in DYING.
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (30) drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        chk("r30_rr",     int'(bus.round_reset), 1);
        chk("r30_freeze", int'(bus.freeze),      1);
        chk("r30_lives",  int'(bus.lives),       START_LIVES);
        drive(0, 0, 0, 0, 0);
        chk("r30_rr_once", int'(bus.round_reset), 0);

        // Exact pause length: 59 ticks keep freeze, the 60th releases it.
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        repeat (PAUSE_FRAMES - 1) drive(1, 0, 0, 0, 0);
        chk("pause_59_freeze", int'(bus.freeze), 1);
        drive(1, 0, 0, 0, 0);
        chk("pause_60_freeze", int'(bus.freeze),      0);
        chk("pause_60_rr",     int'(bus.round_reset), 1);
        drive(0, 0, 0, 0, 0);
        chk("pause_rr_once", int'(bus.round_reset), 0);

        // Random soak.
        for (int i = 0; i < 2500; i++) begin
            drive(coin(40), coin(8), coin(6), coin(10), coin(1));
        end

        // Asynchronous reset in the middle of LEVEL_UP.
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (10) drive(1, 0, 0, 0, 0);
        chk("lu_before_level", int'(bus.level), 1);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_rr",     int'(bus.round_reset), 0);
        chk("arst_freeze", int'(bus.freeze),      1);
        chk("arst_level",  int'(bus.level),       0);
        chk("arst_lives",  int'(bus.lives),       START_LIVES);
        chk("arst_speed",  int'(bus.car_speed),   SPEED_BASE);
        chk("arst_go",     int'(bus.game_over),   0);
        exp_q.push_back(model_expect());
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) drive(0, 0, 0, 0, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
